// File: rtl/pwm_duty_button_conditioner_if.sv
// Button/pulse bundle between the UI pins and the PWM step logic.
// master drives the raw buttons; slave is the conditioner.
interface pwm_duty_button_conditioner_if;
    logic ui_increase_btn;
    logic ui_decrease_btn;
    logic duty_inc;
    logic duty_dec;
    logic btn_conflict;

    modport master (
        output ui_increase_btn,
        output ui_decrease_btn,
        input  duty_inc,
        input  duty_dec,
        input  btn_conflict
    );

    modport slave (
        input  ui_increase_btn,
        input  ui_decrease_btn,
        output duty_inc,
        output duty_dec,
        output btn_conflict
    );
endinterface

// File: rtl/pwm_duty_button_conditioner.sv
// Sync, debounce, optional auto-repeat and arbitration for the duty buttons.
// Auto-repeat is built only when PWM_BTN_AUTO_REPEAT_EN is defined.
module pwm_duty_button_conditioner #(
    parameter int TICK_DIV           = 4,
    parameter int DEBOUNCE_TICKS     = 3,
    parameter int REPEAT_DELAY_TICKS = 8,
    parameter int REPEAT_RATE_TICKS  = 2
) (
    input logic clk,
    input logic rst,
    pwm_duty_button_conditioner_if.slave bus
);

    localparam int RMAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ?
                          REPEAT_DELAY_TICKS : REPEAT_RATE_TICKS;
    localparam int CMAX = (DEBOUNCE_TICKS > RMAX) ? DEBOUNCE_TICKS : RMAX;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CW-1:0] DB_N = CW'(DEBOUNCE_TICKS);
`ifdef PWM_BTN_AUTO_REPEAT_EN
    localparam logic [CW-1:0] DLY_N  = CW'(REPEAT_DELAY_TICKS);
    localparam logic [CW-1:0] RATE_N = CW'(REPEAT_RATE_TICKS);
`endif

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_DB   = 3'd1,
        HELD       = 3'd2,
`ifdef PWM_BTN_AUTO_REPEAT_EN
        REPEAT     = 3'd4,
`endif
        RELEASE_DB = 3'd3
    } state_t;

    // bit 0 = increase, bit 1 = decrease throughout
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    s;
    logic [PW-1:0] pre_q;
    logic          tick;
    state_t        state_q [2];
    state_t        state_d [2];
    logic [CW-1:0] cnt_q   [2];
    logic [CW-1:0] cnt_d   [2];
    logic [1:0]    ev;
    logic          inc_q;
    logic          dec_q;
    logic          conf_q;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    assign s    = sync2_q;
    assign tick = (pre_q == PW'(TICK_DIV - 1));

    // two-flop synchronisers for the asynchronous button pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {bus.ui_decrease_btn, bus.ui_increase_btn};
            sync2_q <= sync1_q;
        end
    end

    // shared sample-tick prescaler
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    // per-button state and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // per-button next state; only tick cycles may move the FSMs
    always_comb begin
        ev = '0;
        for (int i = 0; i < 2; i++) begin
            logic [CW-1:0] inc_c;
            inc_c      = sat_inc(cnt_q[i]);
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (tick) begin
                unique case (state_q[i])
                    IDLE: begin
                        if (s[i]) begin
                            if (DB_N <= CW'(1)) begin
                                state_d[i] = HELD;
                                cnt_d[i]   = '0;
                                ev[i]      = 1'b1;
                            end else begin
                                state_d[i] = PRESS_DB;
                                cnt_d[i]   = CW'(1);
                            end
                        end
                    end
                    PRESS_DB: begin
                        if (!s[i]) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                        end else if (inc_c >= DB_N) begin
                            state_d[i] = HELD;
                            cnt_d[i]   = '0;
                            ev[i]      = 1'b1;
                        end else begin
                            cnt_d[i] = inc_c;
                        end
                    end
                    HELD: begin
                        if (!s[i]) begin
                            state_d[i] = RELEASE_DB;
                            cnt_d[i]   = CW'(1);
                        end
`ifdef PWM_BTN_AUTO_REPEAT_EN
                        else if (inc_c >= DLY_N) begin
                            state_d[i] = REPEAT;
                            cnt_d[i]   = '0;
                            ev[i]      = 1'b1;
                        end else begin
                            cnt_d[i] = inc_c;
                        end
`endif
                    end
`ifdef PWM_BTN_AUTO_REPEAT_EN
                    REPEAT: begin
                        if (!s[i]) begin
                            state_d[i] = RELEASE_DB;
                            cnt_d[i]   = CW'(1);
                        end else if (inc_c >= RATE_N) begin
                            cnt_d[i] = '0;
                            ev[i]    = 1'b1;
                        end else begin
                            cnt_d[i] = inc_c;
                        end
                    end
`endif
                    RELEASE_DB: begin
                        if (s[i]) begin
                            state_d[i] = HELD;
                            cnt_d[i]   = '0;
                        end else if (inc_c >= DB_N) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = inc_c;
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // registered, arbitrated one-cycle output pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_q  <= 1'b0;
            dec_q  <= 1'b0;
            conf_q <= 1'b0;
        end else begin
            inc_q  <= ev[0] & ~ev[1];
            dec_q  <= ev[1] & ~ev[0];
            conf_q <= ev[0] & ev[1];
        end
    end

    assign bus.duty_inc     = inc_q;
    assign bus.duty_dec     = dec_q;
    assign bus.btn_conflict = conf_q;

endmodule

// File: doc/pwm_duty_button_conditioner.md
Name: pwm_duty_button_conditioner

Overview:
- Upstream stage of the PWM duty-cycle generator.
- Conditions two raw push-button inputs (increase / decrease). Each input is synchronised, debounced and optionally auto-repeated.
- Emits clean single-cycle duty_inc / duty_dec pulses that the PWM generator consumes directly as its step commands.
- Simultaneous presses are arbitrated, so the PWM block never sees both pulses in one cycle.

Parameters:
- TICK_DIV, 4, clk cycles per sample tick; must be >= 1; 1 = sample every cycle.
- DEBOUNCE_TICKS, 3, consecutive equal samples needed to accept a press or release; must be >= 1.
- REPEAT_DELAY_TICKS, 8, ticks a button must be held after the press pulse before the first repeat pulse.
- REPEAT_RATE_TICKS, 2, ticks between subsequent repeat pulses.

Ports:
- clk  input  1  system clock; the single clock domain.
- rst  input  1  asynchronous, active-high reset.
- ui_increase_btn  input  1  raw increase button, asynchronous, 1 = pressed.
- ui_decrease_btn  input  1  raw decrease button, asynchronous, 1 = pressed.
- duty_inc  output  1  one-clk pulse: step duty up.
- duty_dec  output  1  one-clk pulse: step duty down.
- btn_conflict  output  1  one-clk pulse: inc and dec events collided and both were dropped.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high.
- Reset: all outputs 0, synchronisers 0, prescaler 0, both FSMs IDLE, all counters 0. Asserting reset mid-operation aborts everything immediately. After release, no pulse is generated until a fresh press is fully debounced.
- Synchroniser: 2-FF per button. FSMs see only the second-stage value (s).
- Prescaler:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - tick = 1 for the single cycle in which the count equals TICK_DIV-1.
  - One prescaler is shared by both buttons.
- Per-button FSM with counter cnt. It changes state only in tick cycles; between ticks it holds state and counter.
  - IDLE: s=1 -> PRESS_DB, cnt=1.
  - PRESS_DB:
    - s=0 -> IDLE.
    - Otherwise cnt+1; when cnt reaches DEBOUNCE_TICKS -> HELD, cnt=0, raise press event.
    - With DEBOUNCE_TICKS=1, IDLE goes directly to HELD with a press event on the first s=1 tick.
  - HELD:
    - s=0 -> RELEASE_DB, cnt=1.
    - Otherwise cnt+1; when cnt reaches REPEAT_DELAY_TICKS -> REPEAT, cnt=0, raise event.
  - REPEAT:
    - s=0 -> RELEASE_DB, cnt=1.
    - Otherwise cnt+1; when cnt reaches REPEAT_RATE_TICKS, raise event and set cnt=0.
  - RELEASE_DB:
    - s=1 -> HELD, cnt=0, no event; this is bounce, and the repeat delay restarts.
    - Otherwise cnt+1; when cnt reaches DEBOUNCE_TICKS -> IDLE.
- Counters: width $clog2(max(DEBOUNCE_TICKS, REPEAT_DELAY_TICKS, REPEAT_RATE_TICKS)+1). Saturate, never wrap.
- Outputs:
  - Registered: an event raised in a tick cycle appears on duty_inc / duty_dec for exactly the next clk cycle.
  - Latency with TICK_DIV=1: pulse high in cycle 2+DEBOUNCE_TICKS, counting the first edge that samples the pin high as cycle 1.
- Arbitration:
  - If inc and dec events are raised in the same tick, both are suppressed and btn_conflict pulses in their place.
  - An event on one button while the other FSM is not IDLE is passed through unchanged.
- Outputs are never high in the same cycle; each pulse is exactly 1 clk wide.

Optional Feature:
- Macro: PWM_BTN_AUTO_REPEAT_EN.
- Defined: HELD -> REPEAT transitions as above; a held button produces a repeat stream.
- Undefined:
  - REPEAT state and the delay/rate counting logic are not compiled. REPEAT_DELAY_TICKS and REPEAT_RATE_TICKS are ignored.
  - HELD waits only for release, so each press yields exactly one pulse however long it is held.

Test Plan:
- Reset: hold rst with both buttons =1 -> all outputs 0. Release rst with buttons still =1 -> exactly one duty_inc and one... no: simultaneous press -> btn_conflict pulse only, and duty_inc=duty_dec=0 throughout.
- Clean press, TICK_DIV=1, DEBOUNCE_TICKS=3: ui_increase_btn 0->1 at cycle 1, held 20 cycles, AUTO_REPEAT off -> single duty_inc pulse in cycle 5, nothing else; release -> no pulse.
- Bounce: ui_decrease_btn toggling 1,0,1,0 every 2 ticks, then stable 1 (defaults) -> no duty_dec until 3 consecutive high ticks, then exactly one pulse. Release with 1-tick glitches -> no extra pulse.
- Auto-repeat on, defaults (TICK_DIV=4): hold increase for 60 ticks -> press pulse at tick 3, repeats at ticks 11, 13, 15, ... (every 2 ticks); pulses stop within DEBOUNCE_TICKS ticks after release.
- Conflict: both buttons rise in the same cycle -> btn_conflict pulse once, no inc/dec. Increase pressed 5 ticks before decrease -> duty_inc then duty_dec, both pass, no conflict.
- Mid-operation reset: assert rst while in REPEAT -> outputs 0 immediately, asynchronously. After release with button still held -> a fresh debounced press pulse, then the repeat delay restarts.
